// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC next-address sequencer: address width, command
// codes, FSM state encodings and a sign-extension helper.
package pc_seq_pkg;

  localparam int unsigned ADDR_W = 16;

  // Command codes on i_cmd
  localparam logic [1:0] CMD_INC  = 2'b00;
  localparam logic [1:0] CMD_ABS  = 2'b01;
  localparam logic [1:0] CMD_REL  = 2'b10;
  localparam logic [1:0] CMD_RVEC = 2'b11;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_LO  = 3'd1;
  localparam logic [2:0] ST_GET_HI  = 3'd2;
  localparam logic [2:0] ST_GET_OFS = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;

  // Sign-extend an 8-bit branch offset to address width
  function automatic logic [ADDR_W-1:0] sext8(input logic [7:0] val);
    return {{(ADDR_W-8){val[7]}}, val};
  endfunction

endpackage

// File: rtl/pc_addr_adder.sv
// Combinational address adder: CUR plus zero-extended STEP, or CUR plus a
// sign-extended 8-bit offset. The wrap output exists only when
// PC_WRAP_FLAG_EN is defined.
module pc_addr_adder
  import pc_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] i_cur,
  input  logic              i_sel_ofs,
  input  logic [7:0]        i_step,
  input  logic [7:0]        i_ofs,
  output logic [ADDR_W-1:0] o_sum
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic              o_wrap
`endif
);

  logic [ADDR_W-1:0] w_addend;

`ifdef PC_WRAP_FLAG_EN
  logic [ADDR_W:0] w_sum_ext;

  // Sum with carry-out; a negative offset wraps when there is no carry (borrow)
  always_comb begin
    w_addend  = i_sel_ofs ? sext8(i_ofs) : {8'h00, i_step};
    w_sum_ext = {1'b0, i_cur} + {1'b0, w_addend};
    o_sum     = w_sum_ext[ADDR_W-1:0];
    o_wrap    = (i_sel_ofs && i_ofs[7]) ? ~w_sum_ext[ADDR_W] : w_sum_ext[ADDR_W];
  end
`else
  // Plain modulo-2^16 sum
  always_comb begin
    w_addend = i_sel_ofs ? sext8(i_ofs) : {8'h00, i_step};
    o_sum    = i_cur + w_addend;
  end
`endif

endmodule

// File: rtl/pc_next_sequencer.sv
// PC next-address sequencer: accepts INC/ABS/REL/RVEC commands, gathers any
// data-bus bytes, then presents the new address with a one-cycle load strobe.
// Optional macro PC_WRAP_FLAG_EN adds the o_wrap output.
module pc_next_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned STEP         = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_cmd,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [7:0]        i_data_in,
  input  logic              i_data_valid,
  input  logic [ADDR_W-1:0] i_cur,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_load,
  output logic              o_busy
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic              o_wrap
`endif
);

  localparam logic [7:0] STEP_B = STEP[7:0];

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_next;
  logic [7:0]        r_lo;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_next_nxt;
  logic [7:0]        w_lo_nxt;
  logic [ADDR_W-1:0] w_sum;
  logic              w_sel_ofs;

`ifdef PC_WRAP_FLAG_EN
  logic r_wrap;
  logic w_wrap_nxt;
  logic w_add_wrap;
`endif

  // Offset path is only needed while waiting for the branch offset
  assign w_sel_ofs = (r_state == ST_GET_OFS);

  pc_addr_adder u_adder (
    .i_cur     (i_cur),
    .i_sel_ofs (w_sel_ofs),
    .i_step    (STEP_B),
    .i_ofs     (i_data_in),
    .o_sum     (w_sum)
`ifdef PC_WRAP_FLAG_EN
    ,
    .o_wrap    (w_add_wrap)
`endif
  );

  // Next-state, next-address and byte-latch decode
  always_comb begin
    w_state_nxt = r_state;
    w_next_nxt  = r_next;
    w_lo_nxt    = r_lo;
`ifdef PC_WRAP_FLAG_EN
    w_wrap_nxt  = r_wrap;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_INC: begin
              w_state_nxt = ST_COMMIT;
              w_next_nxt  = w_sum;
`ifdef PC_WRAP_FLAG_EN
              w_wrap_nxt  = w_add_wrap;
`endif
            end
            CMD_ABS: w_state_nxt = ST_GET_LO;
            CMD_REL: w_state_nxt = ST_GET_OFS;
            default: begin
              w_state_nxt = ST_COMMIT;
              w_next_nxt  = RESET_VECTOR;
`ifdef PC_WRAP_FLAG_EN
              w_wrap_nxt  = 1'b0;
`endif
            end
          endcase
        end
      end
      ST_GET_LO: begin
        if (i_data_valid) begin
          w_lo_nxt    = i_data_in;
          w_state_nxt = ST_GET_HI;
        end
      end
      ST_GET_HI: begin
        if (i_data_valid) begin
          w_next_nxt  = {i_data_in, r_lo};
          w_state_nxt = ST_COMMIT;
`ifdef PC_WRAP_FLAG_EN
          w_wrap_nxt  = 1'b0;
`endif
        end
      end
      ST_GET_OFS: begin
        if (i_data_valid) begin
          w_next_nxt  = w_sum;
          w_state_nxt = ST_COMMIT;
`ifdef PC_WRAP_FLAG_EN
          w_wrap_nxt  = w_add_wrap;
`endif
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
`ifdef PC_WRAP_FLAG_EN
        w_wrap_nxt  = 1'b0;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State registers; reset wins over everything and discards partial commands
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_next  <= RESET_VECTOR;
      r_lo    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_next  <= w_next_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

`ifdef PC_WRAP_FLAG_EN
  // Wrap flag register, only ever set on entry to COMMIT
  always_ff @(posedge i_clk) begin
    if (i_reset) r_wrap <= 1'b0;
    else         r_wrap <= w_wrap_nxt;
  end

  assign o_wrap = r_wrap;
`endif

  assign o_next      = r_next;
  assign o_load      = (r_state == ST_COMMIT);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_cmd_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_pc_next_sequencer.sv
// Directed self-checking bench for pc_next_sequencer (RESET_VECTOR=16'h8000).
module tb_pc_next_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [15:0] cur;
  logic [15:0] next_addr;
  logic        load;
  logic        busy;
`ifdef PC_WRAP_FLAG_EN
  logic        wrap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_next_sequencer #(
    .RESET_VECTOR (16'h8000),
    .STEP         (1)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cmd        (cmd),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_data_in    (data_in),
    .i_data_valid (data_valid),
    .i_cur        (cur),
    .o_next       (next_addr),
    .o_load       (load),
    .o_busy       (busy)
`ifdef PC_WRAP_FLAG_EN
    ,
    .o_wrap       (wrap)
`endif
  );

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wrap(input string tag, input logic exp);
`ifdef PC_WRAP_FLAG_EN
    check(tag, {15'd0, wrap}, {15'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    reset = 1'b1; cmd = 2'b00; cmd_valid = 1'b0;
    data_in = 8'h00; data_valid = 1'b0; cur = 16'h0000;
    #1;
    step(); step();
    check("rst_next", next_addr, 16'h8000);
    check("rst_load", {15'd0, load}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ready", {15'd0, cmd_ready}, 16'd1);
    check_wrap("rst_wrap", 1'b0);
    reset = 1'b0;
    step();

    // INC from 0x1234
    cur = 16'h1234; cmd = 2'b00; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("inc_load", {15'd0, load}, 16'd1);
    check("inc_next", next_addr, 16'h1235);
    check("inc_ready", {15'd0, cmd_ready}, 16'd0);
    check_wrap("inc_wrap", 1'b0);
    step();
    check("inc_load_off", {15'd0, load}, 16'd0);
    check("inc_hold", next_addr, 16'h1235);
    check("inc_ready_back", {15'd0, cmd_ready}, 16'd1);

    // INC wrap-around
    cur = 16'hFFFF; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("incw_load", {15'd0, load}, 16'd1);
    check("incw_next", next_addr, 16'h0000);
    check_wrap("incw_wrap", 1'b1);
    step();
    check_wrap("incw_wrap_clr", 1'b0);

    // Back-to-back INC with CMD_VALID held: 2-cycle period
    cur = 16'h0010; cmd_valid = 1'b1;
    step();
    check("b2b_first", next_addr, 16'h0011);
    check("b2b_load1", {15'd0, load}, 16'd1);
    cur = 16'h0011;
    step();
    check("b2b_gap", {15'd0, load}, 16'd0);
    step();
    check("b2b_second", next_addr, 16'h0012);
    check("b2b_load2", {15'd0, load}, 16'd1);
    cmd_valid = 1'b0;
    step();

    // ABS 0x34, idle, 0x12 with an INC held during GET_HI
    cmd = 2'b01; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("abs_busy", {15'd0, busy}, 16'd1);
    data_in = 8'h34; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    cmd = 2'b00; cmd_valid = 1'b1; cur = 16'h5555;
    step();
    check("abs_gap_load", {15'd0, load}, 16'd0);
    check("abs_gap_ready", {15'd0, cmd_ready}, 16'd0);
    data_in = 8'h12; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("abs_load", {15'd0, load}, 16'd1);
    check("abs_next", next_addr, 16'h1234);
    check("abs_ready", {15'd0, cmd_ready}, 16'd0);
    check_wrap("abs_wrap", 1'b0);
    step();
    check("abs_after_load", {15'd0, load}, 16'd0);
    check("abs_after_ready", {15'd0, cmd_ready}, 16'd1);
    step();
    check("held_inc_next", next_addr, 16'h5556);
    check("held_inc_load", {15'd0, load}, 16'd1);
    cmd_valid = 1'b0;
    step();

    // DATA_VALID in IDLE is ignored
    data_in = 8'hFF; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("dv_idle_busy", {15'd0, busy}, 16'd0);
    check("dv_idle_load", {15'd0, load}, 16'd0);
    check("dv_idle_next", next_addr, 16'h5556);

    // REL -128 and +127 from 0x0100, then a negative wrap
    cur = 16'h0100; cmd = 2'b10; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("rel_wait_load", {15'd0, load}, 16'd0);
    data_in = 8'h80; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("rel_neg_next", next_addr, 16'h0080);
    check("rel_neg_load", {15'd0, load}, 16'd1);
    check_wrap("rel_neg_wrap", 1'b0);
    step();
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    data_in = 8'h7F; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("rel_pos_next", next_addr, 16'h017F);
    step();
    cur = 16'h0002; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    data_in = 8'hFC; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("rel_wrap_next", next_addr, 16'hFFFE);
    check_wrap("rel_wrap_flag", 1'b1);
    step();

    // RVEC
    cmd = 2'b11; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("rvec_next", next_addr, 16'h8000);
    check("rvec_load", {15'd0, load}, 16'd1);
    step();

    // Reset mid-ABS after the low byte
    cur = 16'h4321; cmd = 2'b00; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_abs_next", next_addr, 16'h4322);
    cmd = 2'b01; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    data_in = 8'h99; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_load", {15'd0, load}, 16'd0);
    check("rstmid_busy", {15'd0, busy}, 16'd0);
    check("rstmid_next", next_addr, 16'h8000);
    step();
    check("rstmid_noload", {15'd0, load}, 16'd0);
    cmd = 2'b01; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    data_in = 8'hCD; data_valid = 1'b1;
    step();
    data_in = 8'hAB;
    step();
    data_valid = 1'b0;
    check("abs2_next", next_addr, 16'hABCD);
    check("abs2_load", {15'd0, load}, 16'd1);
    step();
    check("abs2_idle", {15'd0, busy}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_sequencer.md
Name: pc_next_sequencer

Overview:
- Upstream stage of the 16-bit address/PC register in the 8-bit CPU.
- Computes the next 16-bit address and drives the register's 16-bit data input and its load-enable for exactly one cycle per command.
- Supported updates: increment; absolute jump assembled from two 8-bit data-bus bytes (low byte first); relative branch by a signed 8-bit offset; reload of the reset vector.
- The current register output is fed back on CUR for increment and relative arithmetic.

Parameters:
- RESET_VECTOR, 16'h0000, address loaded by the RVEC command and driven on NEXT during reset.
- STEP, 1, unsigned increment applied by the INC command (range 1..255).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD  in  2  command code: 00 INC, 01 ABS, 10 REL, 11 RVEC.
- CMD_VALID  in  1  CMD is valid this cycle.
- CMD_READY  out  1  sequencer can accept a command; equals (state==IDLE).
- DATA_IN  in  8  data-bus byte: address byte or branch offset.
- DATA_VALID  in  1  DATA_IN is valid this cycle.
- CUR  in  16  current value of the downstream 16-bit register.
- NEXT  out  16  next address, to the register's data input.
- LOAD  out  1  one-cycle load strobe, to the register's load input.
- BUSY  out  1  command in progress; equals (state!=IDLE).

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. All outputs are registered.
- Reset state: state=IDLE, NEXT=RESET_VECTOR, LOAD=0, BUSY=0, byte latches=0.
- States: IDLE, GET_LO, GET_HI, GET_OFS, COMMIT.
- Command accept: on the edge where CMD_VALID && CMD_READY.
  - INC: IDLE->COMMIT. NEXT <= CUR+STEP, mod 2^16; CUR is sampled at the accept edge.
  - ABS: IDLE->GET_LO.
  - REL: IDLE->GET_OFS.
  - RVEC: IDLE->COMMIT. NEXT <= RESET_VECTOR.
- GET_LO: stays until DATA_VALID. Captures lo<=DATA_IN, then ->GET_HI.
- GET_HI: stays until DATA_VALID, then NEXT <= {DATA_IN, lo} and ->COMMIT.
- GET_OFS: stays until DATA_VALID, then NEXT <= CUR + sign_extend(DATA_IN), mod 2^16. CUR is sampled at this edge. Then ->COMMIT.
- COMMIT: LOAD=1 for exactly this one cycle. NEXT is stable while LOAD=1. Next state is always IDLE.
- Latency from accept edge to LOAD high:
  - INC, RVEC: 1 cycle.
  - ABS: 1 cycle after the high byte is accepted; minimum 3 cycles.
  - REL: 1 cycle after the offset is accepted; minimum 2 cycles.
- NEXT holds its last value outside COMMIT. LOAD=0 in every state except COMMIT.
- DATA_VALID in IDLE or COMMIT is ignored; no byte is captured.
- CMD_VALID while BUSY is not accepted. The source holds CMD until CMD_READY.
- Back-to-back commands: a command can be accepted in the IDLE cycle that follows COMMIT. The minimum INC-to-INC period is 2 cycles, which gives the register time to update CUR.
- Wrap-around: 16'hFFFF + 1 = 16'h0000. REL below zero wraps, e.g. 16'h0002 + 8'hFC = 16'hFFFE.
- Reset mid-operation aborts the command: a partially captured byte is discarded, no LOAD is issued, and NEXT returns to RESET_VECTOR.
- RESET has priority over every other input on the same edge.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- Defined: adds output port WRAP (1 bit, reset 0).
  - Registered; high in COMMIT only, coincident with LOAD.
  - Set when an INC or REL result wrapped past 16'hFFFF/16'h0000 (carry or borrow out of bit 15).
  - Always 0 for ABS and RVEC.
- Not defined: no WRAP port, no carry logic; behaviour is otherwise identical.

Decomposition:
- Package pc_seq_pkg:
  - Command codes CMD_INC=2'b00, CMD_ABS=2'b01, CMD_REL=2'b10, CMD_RVEC=2'b11.
  - State encoding constants for IDLE, GET_LO, GET_HI, GET_OFS, COMMIT.
  - Address width constant ADDR_W=16.
- One sub-module: pc_addr_adder.
  - Combinational 16-bit adder: CUR plus a zero-extended STEP or a sign-extended 8-bit offset.
  - Outputs a 16-bit sum and a wrap flag; the wrap flag is used only under PC_WRAP_FLAG_EN.

Test Plan:
- Reset: assert RESET for 2 cycles with RESET_VECTOR=16'h8000 -> NEXT=16'h8000, LOAD=0, BUSY=0, CMD_READY=1.
- INC: CUR=16'h1234, CMD=00 accepted -> next cycle LOAD=1, NEXT=16'h1235. With CUR=16'hFFFF -> NEXT=16'h0000, and WRAP=1 if PC_WRAP_FLAG_EN.
- ABS: CMD=01, then bytes 8'h34, 8'h12 with one idle cycle between them -> LOAD=1 once, NEXT=16'h1234, CMD_READY low until the cycle after LOAD.
- REL: CUR=16'h0100, offset 8'h80 -> NEXT=16'h0080. CUR=16'h0100, offset 8'h7F -> NEXT=16'h017F.
- Reset mid-ABS: RESET after the low byte only -> no LOAD, state IDLE, NEXT=RESET_VECTOR. A following ABS with bytes 8'hCD, 8'hAB gives NEXT=16'hABCD.
- Busy/ignore: CMD_VALID held during GET_HI -> not accepted until the IDLE cycle after COMMIT. DATA_VALID in IDLE -> no state change.
